// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - two-digit BCD up-counter with run/pause/step/clear control
//
// Purpose: counts 00..MAX_COUNT in BCD. While running, a prescaler advances the
// count once every TICKS_PER_STEP clocks. While stopped, single-step edges advance it.
// The count wraps MAX_COUNT -> 00 and pulses o_Wrap on the wrap.
//
// Parameters:
//   TICKS_PER_STEP  clocks per automatic increment (2..2^26)
//   MAX_COUNT       terminal count before wrapping to 00 (1..99)
//
// Ports:
//   i_Clk         clock, rising edge
//   i_Rst         synchronous active-high reset
//   i_Start_Stop  debounced level, rising edge toggles run/pause
//   i_Clear       debounced level, rising edge zeroes the count and stops
//   i_Step        debounced level, rising edge increments once while stopped
//   o_Tens        BCD tens digit
//   o_Ones        BCD ones digit
//   o_Running     high while in RUN
//   o_Wrap        one-cycle pulse on MAX_COUNT -> 00
//   o_Tens_Blank  high when o_Tens == 0 (present only with
//                 BCD_COUNT_CTRL_BLANK_LEAD_ZERO_EN defined)
//
// Build option: define BCD_COUNT_CTRL_BLANK_LEAD_ZERO_EN to add o_Tens_Blank.

module bcd_count_ctrl #(
  parameter int TICKS_PER_STEP = 25000000,
  parameter int MAX_COUNT      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start_Stop,
  input  logic       i_Clear,
  input  logic       i_Step,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Running,
  output logic       o_Wrap
`ifdef BCD_COUNT_CTRL_BLANK_LEAD_ZERO_EN
  ,
  output logic       o_Tens_Blank
`endif
);

  localparam int PW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]    MAX_TENS   = 4'(MAX_COUNT / 10);
  localparam logic [3:0]    MAX_ONES   = 4'(MAX_COUNT % 10);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            wrap_q, wrap_d;
  logic            running_q;
  logic            start_prev_q, clear_prev_q, step_prev_q;

  logic            start_rise, clear_rise, step_rise;
  logic            tick;
  logic            at_max;
  logic            incr;

  assign start_rise = i_Start_Stop & ~start_prev_q;
  assign clear_rise = i_Clear      & ~clear_prev_q;
  assign step_rise  = i_Step       & ~step_prev_q;

  assign tick   = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    incr    = 1'b0;

    if (clear_rise) begin
      // Clear beats everything, including a coincident tick (no wrap pulse).
      state_d = S_IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else begin
      // The prescaler advances for every cycle spent in RUN, including the
      // cycle that ends in a pause, so a resumed partial period loses nothing.
      if (state_q == S_RUN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end

      if (start_rise) begin
        // A tick landing on the pause edge is dropped.
        case (state_q)
          S_IDLE: begin
            state_d = S_RUN;
            presc_d = '0;
          end
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end else if (tick) begin
        incr = 1'b1;
      end else if (step_rise && (state_q != S_RUN)) begin
        incr = 1'b1;
        if (state_q == S_IDLE) begin
          state_d = S_PAUSE;
        end
      end

      if (incr) begin
        if (at_max) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      presc_q      <= '0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
      // Held high so a button pressed through reset is not seen as an edge.
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
      step_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      presc_q      <= presc_d;
      wrap_q       <= wrap_d;
      running_q    <= (state_d == S_RUN);
      start_prev_q <= i_Start_Stop;
      clear_prev_q <= i_Clear;
      step_prev_q  <= i_Step;
    end
  end

  assign o_Tens    = tens_q;
  assign o_Ones    = ones_q;
  assign o_Running = running_q;
  assign o_Wrap    = wrap_q;

`ifdef BCD_COUNT_CTRL_BLANK_LEAD_ZERO_EN
  logic blank_q;

  // Registered from the next tens value so it changes on the same edge as o_Tens.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      blank_q <= 1'b1;
    end else begin
      blank_q <= (tens_d == 4'd0);
    end
  end

  assign o_Tens_Blank = blank_q;
`else
  // Leading-zero flag not built; the decoder shows both digits unconditionally.
`endif

endmodule
